// File: rtl/agc_gain_sequencer.sv
// Steps the RF front-end gain code toward the AGC-requested target in bounded
// increments, waiting out analog settling after each step and blanking samples meanwhile.
module agc_gain_sequencer #(
  parameter int CONTROL_WORD_WIDTH = 8,
  parameter int NUM_GAIN_LEVELS    = 17,
  parameter int DEFAULT_GAIN       = 8,
  parameter int MAX_STEP           = 4,
  parameter int SETTLE_CYCLES      = 16,
  parameter int CNT_WIDTH          = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [CONTROL_WORD_WIDTH-1:0] control_word,
  input  logic                          control_word_valid,
  input  logic                          packet_start,
  output logic [CONTROL_WORD_WIDTH-1:0] gain_code,
  output logic                          gain_strobe,
  output logic                          sample_blank,
  output logic                          gain_locked,
  output logic [3:0]                    step_count
);

  localparam int W = CONTROL_WORD_WIDTH;
  localparam logic [W-1:0]         MAX_CODE     = W'(NUM_GAIN_LEVELS - 1);
  localparam logic [W-1:0]         DEFAULT_CODE = W'(DEFAULT_GAIN);
  localparam logic [W-1:0]         STEP_U       = W'(MAX_STEP);
  localparam logic signed [W:0]    STEP_S       = (W+1)'(MAX_STEP);
  localparam logic [CNT_WIDTH-1:0] SETTLE_LOAD  = CNT_WIDTH'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STEP   = 2'd1,
    SETTLE = 2'd2,
    LOCKED = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [W-1:0]          gain_q, gain_d;
  logic [W-1:0]          target_q, target_d;
  logic                  strobe_q, strobe_d;
  logic [3:0]            steps_q, steps_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic [W-1:0]          req_sat;
  logic signed [W:0]     diff;
  logic [W-1:0]          gain_stepped;

  // Out-of-range requests clamp to the top legal code.
  always_comb begin
    req_sat = (control_word > MAX_CODE) ? MAX_CODE : control_word;
  end

  always_comb begin
    diff = $signed({1'b0, target_q}) - $signed({1'b0, gain_q});
    if (diff > STEP_S) begin
      gain_stepped = gain_q + STEP_U;
    end else if (diff < -STEP_S) begin
      gain_stepped = gain_q - STEP_U;
    end else begin
      gain_stepped = target_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    gain_d   = gain_q;
    target_d = target_q;
    strobe_d = 1'b0;
    steps_d  = steps_q;
    cnt_d    = cnt_q;
    if (packet_start) begin
      state_d  = IDLE;
      gain_d   = DEFAULT_CODE;
      target_d = DEFAULT_CODE;
      strobe_d = (gain_q != DEFAULT_CODE);
      steps_d  = 4'd0;
      cnt_d    = '0;
    end else begin
      case (state_q)
        IDLE, LOCKED: begin
          if (control_word_valid) begin
            target_d = req_sat;
            steps_d  = 4'd0;
            state_d  = (req_sat == gain_q) ? LOCKED : STEP;
          end
        end
        STEP: begin
          if (control_word_valid) target_d = req_sat;
          gain_d   = gain_stepped;
          steps_d  = (steps_q == 4'd15) ? steps_q : steps_q + 4'd1;
          strobe_d = 1'b1;
          cnt_d    = SETTLE_LOAD;
          state_d  = SETTLE;
        end
        SETTLE: begin
          // A request landing in the final settle cycle already steers the decision.
          if (control_word_valid) target_d = req_sat;
          if (cnt_q == '0) begin
            state_d = (gain_q != target_d) ? STEP : LOCKED;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gain_q   <= DEFAULT_CODE;
      target_q <= DEFAULT_CODE;
      strobe_q <= 1'b0;
      steps_q  <= 4'd0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      gain_q   <= gain_d;
      target_q <= target_d;
      strobe_q <= strobe_d;
      steps_q  <= steps_d;
      cnt_q    <= cnt_d;
    end
  end

  assign gain_code    = gain_q;
  assign gain_strobe  = strobe_q;
  assign sample_blank = (state_q == STEP) || (state_q == SETTLE);
  assign gain_locked  = (state_q == LOCKED);
  assign step_count   = steps_q;

endmodule

// File: tb/tb_agc_gain_sequencer.sv
// Directed bench for agc_gain_sequencer: linear stimulus with hand-computed
// expectations checked by immediate assertions.
module tb_agc_gain_sequencer;

  logic       clk;
  logic       rst_n;
  logic [7:0] control_word;
  logic       control_word_valid;
  logic       packet_start;
  logic [7:0] gain_code;
  logic       gain_strobe;
  logic       sample_blank;
  logic       gain_locked;
  logic [3:0] step_count;

  int checks;
  int errors;
  int max_gain;

  agc_gain_sequencer dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .control_word       (control_word),
    .control_word_valid (control_word_valid),
    .packet_start       (packet_start),
    .gain_code          (gain_code),
    .gain_strobe        (gain_strobe),
    .sample_blank       (sample_blank),
    .gain_locked        (gain_locked),
    .step_count         (step_count)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic request(input logic [7:0] cw);
    control_word       = cw;
    control_word_valid = 1'b1;
    tick();
    control_word_valid = 1'b0;
  endtask

  task automatic pkt(input logic with_valid, input logic [7:0] cw);
    packet_start       = 1'b1;
    control_word       = cw;
    control_word_valid = with_valid;
    tick();
    packet_start       = 1'b0;
    control_word_valid = 1'b0;
  endtask

  task automatic check_outs(input string tag, input int g, input int s, input int b,
                            input int l, input int sc);
    check({tag, ".gain"},   32'(gain_code),    g);
    check({tag, ".strobe"}, 32'(gain_strobe),  s);
    check({tag, ".blank"},  32'(sample_blank), b);
    check({tag, ".locked"}, 32'(gain_locked),  l);
    check({tag, ".steps"},  32'(step_count),   sc);
  endtask

  initial begin
    checks             = 0;
    errors             = 0;
    rst_n              = 1'b0;
    control_word       = 8'd0;
    control_word_valid = 1'b0;
    packet_start       = 1'b0;
    cyc(2);
    rst_n = 1'b1;

    // Reset state held through 10 idle cycles
    cyc(10);
    check_outs("reset", 8, 0, 0, 0, 0);
    check("reset.state", 32'(dut.state_q), 0);

    // packet_start with gain already at default: no strobe
    pkt(1'b0, 8'd0);
    check_outs("pkt_nochange", 8, 0, 0, 0, 0);

    // Request equal to current gain locks immediately
    request(8'd8);
    check_outs("same_t1", 8, 0, 0, 1, 0);
    tick();
    check_outs("same_t2", 8, 0, 0, 1, 0);

    // Request 16 from 8: two steps, 17-cycle strobe spacing
    request(8'd16);
    check_outs("up_t1", 8, 0, 1, 0, 0);
    tick();
    check_outs("up_t2", 12, 1, 1, 0, 1);
    tick();
    check_outs("up_t3", 12, 0, 1, 0, 1);
    cyc(15);
    check_outs("up_t18", 12, 0, 1, 0, 1);
    tick();
    check_outs("up_t19", 16, 1, 1, 0, 2);
    cyc(15);
    check_outs("up_t34", 16, 0, 1, 0, 2);
    tick();
    check_outs("up_t35", 16, 0, 0, 1, 2);

    // Back to default: gain changes so strobe fires once
    pkt(1'b0, 8'd0);
    check_outs("pkt_back", 8, 1, 0, 0, 0);
    check("pkt_back.state", 32'(dut.state_q), 0);
    tick();
    check_outs("pkt_back2", 8, 0, 0, 0, 0);

    // Out-of-range request saturates to 16
    request(8'd200);
    max_gain = 0;
    for (int i = 0; i < 40; i++) begin
      if (int'(gain_code) > max_gain) max_gain = int'(gain_code);
      tick();
    end
    check("sat.max", max_gain, 16);
    check_outs("sat_end", 16, 0, 0, 1, 2);

    // Reversal: 16 requested, then 6 during the first settle
    pkt(1'b0, 8'd0);
    request(8'd16);
    tick();
    check_outs("rev_t2", 12, 1, 1, 0, 1);
    request(8'd6);
    check_outs("rev_t3", 12, 0, 1, 0, 1);
    cyc(15);
    check_outs("rev_t18", 12, 0, 1, 0, 1);
    tick();
    check_outs("rev_t19", 8, 1, 1, 0, 2);
    cyc(16);
    check_outs("rev_t35", 8, 0, 1, 0, 2);
    tick();
    check_outs("rev_t36", 6, 1, 1, 0, 3);
    cyc(15);
    check_outs("rev_t51", 6, 0, 1, 0, 3);
    tick();
    check_outs("rev_t52", 6, 0, 0, 1, 3);

    // packet_start during settle at 12 overrides a simultaneous request
    pkt(1'b0, 8'd0);
    check_outs("abort_pre", 8, 1, 0, 0, 0);
    request(8'd16);
    tick();
    check_outs("abort_settle", 12, 1, 1, 0, 1);
    cyc(3);
    pkt(1'b1, 8'd2);
    check_outs("abort_t1", 8, 1, 0, 0, 0);
    check("abort_t1.state", 32'(dut.state_q), 0);
    tick();
    check_outs("abort_t2", 8, 0, 0, 0, 0);
    cyc(5);
    check_outs("abort_t7", 8, 0, 0, 0, 0);
    check("abort_t7.state", 32'(dut.state_q), 0);

    // Downward request to 0, then asynchronous reset mid-step
    request(8'd0);
    tick();
    check_outs("down_t2", 4, 1, 1, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("async_rst", 8, 0, 0, 0, 0);
    check("async_rst.state", 32'(dut.state_q), 0);
    cyc(2);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(2);
    check_outs("post_rst", 8, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/agc_gain_sequencer.md
Name: agc_gain_sequencer

Overview:
- Downstream of the AGC top level. Consumes the AGC gain control word and its valid strobe.
- Walks the RF front-end gain code to the requested target in bounded steps, waiting a fixed analog settling time after each step.
- Blanks the I/Q sample stream while the gain is in transition.
- Reports when the gain is locked, so baseband processing can trust the samples.

Parameters:
- CONTROL_WORD_WIDTH, 8, width of control_word and gain_code.
- NUM_GAIN_LEVELS, 17, number of legal gain codes (0 to NUM_GAIN_LEVELS-1).
- DEFAULT_GAIN, 8, gain code applied after reset and on packet_start.
- MAX_STEP, 4, largest gain-code change allowed per step (must be ≥1).
- SETTLE_CYCLES, 16, clk cycles to wait after each step (must be ≥1).
- CNT_WIDTH, 8, width of the settle counter (must satisfy 2^CNT_WIDTH > SETTLE_CYCLES).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- control_word  in  CONTROL_WORD_WIDTH  requested gain code from the AGC.
- control_word_valid  in  1  one-cycle strobe; control_word is valid in that cycle.
- packet_start  in  1  one-cycle strobe at the start of a new packet; re-arms to DEFAULT_GAIN.
- gain_code  out  CONTROL_WORD_WIDTH  registered gain code driven to the RF front-end.
- gain_strobe  out  1  one-cycle pulse in the first cycle a new gain_code is presented.
- sample_blank  out  1  high while gain is changing or settling; downstream discards samples.
- gain_locked  out  1  high when gain_code equals the target and settling is complete.
- step_count  out  4  steps taken since the last accepted request; saturates at 15.

Behaviour:
- Reset (async assert, sync release) sets:
  - state=IDLE, gain_code=DEFAULT_GAIN, target=DEFAULT_GAIN
  - gain_strobe=0, sample_blank=0, gain_locked=0, step_count=0, settle counter=0
- States:
  - IDLE: waiting for a request.
  - STEP: gain_code is being moved.
  - SETTLE: counting settling time.
  - LOCKED: gain has reached target and settled.
- Target capture: target = min(control_word, NUM_GAIN_LEVELS-1), i.e. out-of-range requests saturate.
- IDLE or LOCKED with control_word_valid at cycle T:
  - target is captured at the edge ending T, and step_count is cleared.
  - If the saturated target equals gain_code: state=LOCKED in T+1 with gain_locked=1. No strobe, no blanking.
  - Otherwise: state=STEP in T+1, gain_locked=0, sample_blank=1 from T+1.
- STEP, lasting exactly 1 cycle:
  - At the edge ending the cycle, gain_code moves toward target by min(|target-gain_code|, MAX_STEP).
  - step_count increments (saturating at 15).
  - Next state is SETTLE.
  - gain_strobe=1 in the first SETTLE cycle only.
- SETTLE, lasting exactly SETTLE_CYCLES cycles:
  - The counter loads SETTLE_CYCLES-1 on entry and decrements each cycle.
  - In the cycle with counter=0: next state is STEP if gain_code≠target, otherwise LOCKED.
  - sample_blank stays 1 through the last SETTLE cycle and is 0 in the first LOCKED cycle, where gain_locked=1.
  - Consecutive strobes are therefore spaced SETTLE_CYCLES+1 cycles apart.
- Request during STEP or SETTLE:
  - The target is updated (saturated) and step_count is not cleared.
  - The current step and settle continue without abort.
  - The next STEP decision uses the new target, which may reverse direction.
- packet_start, highest priority in any state:
  - Next cycle: state=IDLE, target=DEFAULT_GAIN, gain_locked=0, sample_blank=0, step_count=0, counter=0.
  - gain_code=DEFAULT_GAIN.
  - gain_strobe=1 for one cycle only if gain_code changed.
  - A simultaneous control_word_valid in the same cycle is ignored.
- Arithmetic: the step difference is computed as a signed value CONTROL_WORD_WIDTH+1 bits wide. gain_code never leaves 0..NUM_GAIN_LEVELS-1.
- Asserting reset mid-sequence returns all outputs to their reset values immediately.

Test Plan:
- Reset then idle 10 cycles → gain_code=8, gain_strobe=0, sample_blank=0, gain_locked=0, step_count=0.
- control_word=8 with valid at T → gain_locked=1 at T+1, no gain_strobe, sample_blank stays 0, step_count=0.
- control_word=16 with valid at T → sample_blank=1 from T+1.
  - gain_code=12 with strobe at T+2; gain_code=16 with strobe at T+19.
  - sample_blank falls and gain_locked=1 at T+35; step_count=2.
- control_word=200 → target saturates to 16; gain_code sequence 8→12→16; gain_locked at end, never exceeds 16.
- control_word=16, then control_word=6 with valid during the first SETTLE → gain_code sequence 12→8→6, three strobes, final gain_locked=1 with gain_code=6, step_count=3.
- packet_start while gain_code=12 in SETTLE, with control_word_valid in the same cycle → next cycle gain_code=8, gain_strobe=1 for one cycle, state IDLE, sample_blank=0, gain_locked=0. Request ignored.
